// File: rtl/print_arb_pkg.sv
// Shared types and constants for print_arbiter and its round-robin picker.
// The optional separator feature is selected with the PRINT_ARB_SEP_EN macro in print_arbiter.
package print_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    SEP_WAIT = 3'd2,
    SEP      = 3'd3,
    DONE     = 3'd4,
    RELEASE  = 3'd5
  } state_e;

  localparam logic TYPE_BYTE = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

  // Print takes a 32-bit data bus; a byte job only uses the low 8 bits.
  function automatic logic [31:0] sep_word(input logic [7:0] ch);
    return {24'h0, ch};
  endfunction

endpackage

// File: rtl/print_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request strictly
// after last_gnt, wrapping around, so the last winner gets lowest priority.
module rr_pick
  import print_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last_gnt,
  output logic               valid,
  output logic [GNT_W-1:0]   idx
);

  logic [GNT_W-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = GNT_W'((int'(last_gnt) + off) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/print_arbiter.sv
// Round-robin arbiter sharing one Print formatter among NUM_REQ requesters.
// Define PRINT_ARB_SEP_EN to follow every word job with a SEP_CHAR byte job.
module print_arbiter
  import print_arb_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter int         GNT_W    = 2,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_type,
  input  logic [32*NUM_REQ-1:0]  dout,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [GNT_W-1:0]       gnt_id,
  output logic [31:0]            dout_tx,
  output logic                   type_tx,
  output logic                   req_tx,
  input  logic                   ack_tx
);

`ifdef PRINT_ARB_SEP_EN
  localparam bit SEP_EN = 1'b1;
`else
  localparam bit SEP_EN = 1'b0;
`endif

  state_e           state;
  logic [GNT_W-1:0] last_gnt;
  logic             pick_valid;
  logic [GNT_W-1:0] pick_idx;
  logic [31:0]      dout_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign dout_arr[i] = dout[32*i +: 32];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // NOTE: all state uses non-blocking assignments so every register updates
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last_gnt <= GNT_W'(NUM_REQ - 1);
      gnt_id   <= '0;
      dout_tx  <= '0;
      type_tx  <= TYPE_BYTE;
      req_tx   <= 1'b0;
      busy     <= 1'b0;
      ack      <= '0;
    end else begin
      ack <= '0;
      case (state)
        // Print ignores requests during its ack cycle, so never launch one then.
        IDLE: begin
          if (pick_valid && !ack_tx) begin
            gnt_id   <= pick_idx;
            last_gnt <= pick_idx;
            dout_tx  <= dout_arr[pick_idx];
            type_tx  <= req_type[pick_idx];
            req_tx   <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ack_tx) begin
            req_tx <= 1'b0;
            state  <= (SEP_EN && type_tx == TYPE_WORD) ? SEP_WAIT : DONE;
          end
        end
        SEP_WAIT: begin
          if (!ack_tx) begin
            dout_tx <= sep_word(SEP_CHAR);
            type_tx <= TYPE_BYTE;
            req_tx  <= 1'b1;
            state   <= SEP;
          end
        end
        SEP: begin
          if (ack_tx) begin
            req_tx <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          ack   <= NUM_REQ'(1) << gnt_id;
          state <= RELEASE;
        end
        // Hold off until the winner drops its request, so it is not re-granted stale.
        RELEASE: begin
          if (!req[gnt_id] && !ack_tx) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_print_arbiter.sv
// Self-checking bench for print_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a job-level reference model (honours PRINT_ARB_SEP_EN).
module tb_print_arbiter;
  import print_arb_pkg::*;

  localparam int         NUM_REQ  = 4;
  localparam int         GNT_W    = 2;
  localparam logic [7:0] SEP_CHAR = 8'h20;
`ifdef PRINT_ARB_SEP_EN
  localparam bit SEP_EN = 1'b1;
`else
  localparam bit SEP_EN = 1'b0;
`endif

  logic                  clk;
  logic                  rstn;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_type;
  logic [32*NUM_REQ-1:0] dout;
  logic [NUM_REQ-1:0]    ack;
  logic                  busy;
  logic [GNT_W-1:0]      gnt_id;
  logic [31:0]           dout_tx;
  logic                  type_tx;
  logic                  req_tx;
  logic                  ack_tx;

  print_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .GNT_W    (GNT_W),
    .SEP_CHAR (SEP_CHAR)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_type (req_type),
    .dout     (dout),
    .ack      (ack),
    .busy     (busy),
    .gnt_id   (gnt_id),
    .dout_tx  (dout_tx),
    .type_tx  (type_tx),
    .req_tx   (req_tx),
    .ack_tx   (ack_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job level) ----------------
  logic               m_busy, m_req_tx, m_type_tx, m_fin;
  logic [31:0]        m_dout_tx;
  logic [NUM_REQ-1:0] m_ack;
  int                 m_gnt, m_last;
  logic [32:0]        m_q[$];     // Print transactions still owed for the current job

  int          ack_q[$];          // requester index of every observed ack pulse
  logic [32:0] tx_q[$];           // {type,data} of every Print transaction accepted
  int          p_wait, p_lat_max;

  int hold_cfg[NUM_REQ], hold_left[NUM_REQ], rereq[NUM_REQ];
  bit raise_next[NUM_REQ];

  task automatic model_reset();
    m_busy = 0; m_req_tx = 0; m_type_tx = 0; m_fin = 0;
    m_dout_tx = '0; m_ack = '0; m_gnt = 0; m_last = NUM_REQ - 1;
    m_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_step();
    logic [NUM_REQ-1:0] nack;
    nack = '0;
    if (!m_busy) begin
      if (req != '0 && !ack_tx) begin
        int w;
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (w < 0 && req[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
        m_gnt  = w;
        m_last = w;
        m_q.push_back({req_type[w], dout[32*w +: 32]});
        if (SEP_EN && req_type[w]) m_q.push_back({1'b0, 24'h0, SEP_CHAR});
        {m_type_tx, m_dout_tx} = m_q[0];
        m_req_tx = 1;
        m_busy   = 1;
      end
    end else if (m_req_tx) begin
      if (ack_tx) begin
        m_req_tx = 0;
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_fin = 1;
      end
    end else if (m_q.size() != 0) begin
      if (!ack_tx) begin
        {m_type_tx, m_dout_tx} = m_q[0];
        m_req_tx = 1;
      end
    end else if (m_fin) begin
      nack[m_gnt] = 1'b1;
      m_fin = 0;
    end else if (!req[m_gnt] && !ack_tx) begin
      m_busy = 0;
    end
    m_ack = nack;
  endtask

  task automatic compare_all();
    check("req_tx", req_tx, m_req_tx);
    check("busy", busy, m_busy);
    check("ack", ack, m_ack);
    check("ack_onehot0", $onehot0(ack), 1'b1);
    check("gnt_id", gnt_id, m_gnt);
    if (m_req_tx) begin
      check("dout_tx", dout_tx, m_dout_tx);
      check("type_tx", type_tx, m_type_tx);
    end
    for (int i = 0; i < NUM_REQ; i++) if (ack[i]) ack_q.push_back(i);
  endtask

  // Print stand-in: acks a pending request after 0..p_lat_max idle cycles, one-cycle pulse.
  task automatic print_drive();
    if (ack_tx) ack_tx = 1'b0;
    else if (m_req_tx) begin
      if (p_wait == 0) begin
        ack_tx = 1'b1;
        tx_q.push_back({type_tx, dout_tx});
        p_wait = $urandom_range(0, p_lat_max);
      end else p_wait--;
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_all();
    print_drive();
  endtask

  task automatic drop_req(input int i);
    req[i] = 1'b0;
    if (rereq[i] > 0) begin
      rereq[i]--;
      raise_next[i] = 1'b1;
    end
  endtask

  task automatic directed_react();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (raise_next[i]) begin
        req[i] = 1'b1;
        raise_next[i] = 1'b0;
      end else if (req[i] && m_ack[i]) begin
        hold_left[i] = hold_cfg[i];
        if (hold_left[i] == 0) drop_req(i);
      end else if (hold_left[i] > 0) begin
        hold_left[i]--;
        if (hold_left[i] == 0) drop_req(i);
      end
    end
  endtask

  task automatic run_until_acks(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (ack_q.size() < n && c < budget) begin
      cycle();
      directed_react();
      c++;
    end
    check({name, "_acks_in_time"}, ack_q.size() >= n, 1'b1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      raise_next[i] = 0; rereq[i] = 0; hold_left[i] = 0; hold_cfg[i] = 0;
    end
    while ((m_busy || ack_tx) && c < 100) begin
      cycle();
      c++;
    end
    cycle();
    check("drain_idle", busy, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req = '0; req_type = '0; ack_tx = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dout[32*i +: 32] = $urandom;
      raise_next[i] = 0; rereq[i] = 0; hold_left[i] = 0; hold_cfg[i] = 0;
    end
    p_wait = 0;
    model_reset();
    ack_q.delete();
    tx_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] exp5[$];
    int exp2[4] = '{0, 1, 2, 3};
    p_lat_max = 0;

    // Reset state
    do_reset();
    rstn = 1'b0;
    @(negedge clk);
    check("rst_req_tx", req_tx, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 4'b0000);
    check("rst_gnt_id", gnt_id, 2'd0);
    check("rst_dout_tx", dout_tx, 32'h0);
    rstn = 1'b1;

    // 1. Single byte job from requester 0
    p_lat_max = 0; p_wait = 0;
    dout[31:0] = 32'h41; req_type = '0; req = 4'b0001;
    cycle();
    check("t1_req_tx", req_tx, 1'b1);
    check("t1_dout_tx", dout_tx, 32'h41);
    check("t1_type_tx", type_tx, 1'b0);
    cycle();
    check("t1_req_tx_drop", req_tx, 1'b0);
    check("t1_ack_not_yet", ack, 4'b0000);
    cycle();
    check("t1_ack", ack, 4'b0001);
    check("t1_busy_held", busy, 1'b1);
    cycle();
    check("t1_ack_once", ack, 4'b0000);
    check("t1_busy_stale", busy, 1'b1);
    req[0] = 1'b0;
    cycle();
    check("t1_busy_clear", busy, 1'b0);

    // 2. Contention right after reset
    do_reset();
    p_lat_max = 2;
    req = 4'b1111;
    run_until_acks(4, 200, "t2");
    for (int k = 0; k < 4; k++)
      check("t2_grant_order", (k < ack_q.size()) ? ack_q[k] : -1, exp2[k]);
    drain();

    // 3. Fairness between two eager requesters (last grant was 3)
    ack_q.delete();
    rereq[1] = 3; rereq[2] = 3;
    req = 4'b0110;
    run_until_acks(8, 400, "t3");
    for (int k = 0; k < 8; k++)
      check("t3_alternate", (k < ack_q.size()) ? ack_q[k] : -1, (k % 2 == 0) ? 1 : 2);
    drain();

    // 4. Stale request held after ack must not be re-granted
    ack_q.delete();
    hold_cfg[3] = 5;
    req = 4'b1000;
    run_until_acks(1, 100, "t4");
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t4_no_req_tx", req_tx, 1'b0);
      check("t4_busy", busy, 1'b1);
      directed_react();
    end
    check("t4_req_dropped", req[3], 1'b0);
    cycle();
    check("t4_busy_clear", busy, 1'b0);
    cycle();
    check("t4_still_quiet", req_tx, 1'b0);
    drain();

    // 5. Word job (with separator byte when enabled)
    ack_q.delete();
    tx_q.delete();
    req_type[2] = TYPE_WORD;
    dout[95:64] = 32'hDEADBEEF;
    req = 4'b0100;
    run_until_acks(1, 100, "t5");
    exp5.push_back({1'b1, 32'hDEADBEEF});
    if (SEP_EN) exp5.push_back({1'b0, 32'h20});
    check("t5_job_count", tx_q.size(), exp5.size());
    for (int k = 0; k < exp5.size(); k++)
      check("t5_tx", (k < tx_q.size()) ? tx_q[k] : 33'h0, exp5[k]);
    check("t5_ack_id", (ack_q.size() > 0) ? ack_q[0] : -1, 2);
    drain();

    // 6. Reset while a job is in ISSUE
    req_type = '0;
    p_wait = 20;
    req = 4'b0001;
    cycle();
    check("t6_issue", req_tx, 1'b1);
    req = '0;
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_req_tx", req_tx, 1'b0);
    check("t6_rst_ack", ack, 4'b0000);
    check("t6_rst_busy", busy, 1'b0);
    model_reset();
    ack_tx = 1'b0;
    p_wait = 0;
    ack_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    req = 4'b1000;
    cycle();
    check("t6_first_gnt", gnt_id, 2'd3);
    check("t6_req_tx", req_tx, 1'b1);
    run_until_acks(1, 100, "t6");
    drain();

    // Randomized traffic, including early drops and stale holds
    p_lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_ack[i]) hold_left[i] = $urandom_range(1, 4);
        if (hold_left[i] > 0) begin
          hold_left[i]--;
          if (hold_left[i] == 0) req[i] = 1'b0;
        end else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        req_type[i] = 1'($urandom_range(0, 1));
        dout[32*i +: 32] = $urandom;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
